// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants, font table and digit index type for the FND scan controller
package fnd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int MAX_VALUE  = 9999;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [1:0] digit_idx_t;

    // Active-low g..a pattern for one BCD digit; anything out of range is dark.
    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    seg_encode = SEG_0;
            4'd1:    seg_encode = SEG_1;
            4'd2:    seg_encode = SEG_2;
            4'd3:    seg_encode = SEG_3;
            4'd4:    seg_encode = SEG_4;
            4'd5:    seg_encode = SEG_5;
            4'd6:    seg_encode = SEG_6;
            4'd7:    seg_encode = SEG_7;
            4'd8:    seg_encode = SEG_8;
            4'd9:    seg_encode = SEG_9;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/digitDivider.sv
// rtl/digitDivider.sv - combinational binary to four decimal digits splitter
module digitDivider (
    input  logic [13:0] i_value,
    input  logic        i_clear,
    output logic [3:0]  o_digit0,
    output logic [3:0]  o_digit1,
    output logic [3:0]  o_digit2,
    output logic [3:0]  o_digit3
);

    logic [13:0] q10;
    logic [13:0] q100;
    logic [13:0] q1000;

    always_comb begin
        q10      = i_value / 14'd10;
        q100     = i_value / 14'd100;
        q1000    = i_value / 14'd1000;
        o_digit0 = 4'(i_value % 14'd10);
        o_digit1 = 4'(q10 % 14'd10);
        o_digit2 = 4'(q100 % 14'd10);
        o_digit3 = 4'(q1000 % 14'd10);
        if (i_clear) begin
            o_digit0 = 4'd0;
            o_digit1 = 4'd0;
            o_digit2 = 4'd0;
            o_digit3 = 4'd0;
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - time-multiplexed 4-digit common-anode FND scan controller
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 4_000,
    parameter int BLANK_LZ = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [13:0] i_value,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_clear,
    input  logic [3:0]  i_dp,
    output logic [3:0]  o_fnd_comm,
    output logic [7:0]  o_fnd_font,
    output logic        o_frame_done
);

    localparam int DIV    = CLK_HZ / SCAN_HZ;
    localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DIV - 1);
    localparam digit_idx_t        DIGIT_LAST = digit_idx_t'(NUM_DIGITS - 1);
    localparam logic [13:0]       VALUE_CAP  = 14'(MAX_VALUE);

    logic [13:0]       r_pend;
    logic              r_pend_full;
    logic [13:0]       r_disp;
    logic [TICK_W-1:0] r_tick;
    digit_idx_t        r_digit;

    logic [3:0]  dig0, dig1, dig2, dig3;
    logic [3:0]  sel_digit;
    logic        lz_blank;
    logic [6:0]  seg;
    logic [13:0] sat_value;
    logic        accept;
    logic        frame_end;

    digitDivider u_divider (
        .i_value  (r_disp),
        .i_clear  (1'b0),
        .o_digit0 (dig0),
        .o_digit1 (dig1),
        .o_digit2 (dig2),
        .o_digit3 (dig3)
    );

    assign o_ready   = ~r_pend_full;
    assign accept    = i_valid & ~r_pend_full;
    assign sat_value = (i_value > VALUE_CAP) ? VALUE_CAP : i_value;
    assign frame_end = i_enable && (r_tick == TICK_LAST) && (r_digit == DIGIT_LAST);

    // A digit is a leading zero only when it and every higher digit are zero.
    always_comb begin
        sel_digit = dig0;
        lz_blank  = 1'b0;
        case (r_digit)
            2'd0: sel_digit = dig0;
            2'd1: begin
                sel_digit = dig1;
                lz_blank  = (dig3 == 4'd0) && (dig2 == 4'd0) && (dig1 == 4'd0);
            end
            2'd2: begin
                sel_digit = dig2;
                lz_blank  = (dig3 == 4'd0) && (dig2 == 4'd0);
            end
            default: begin
                sel_digit = dig3;
                lz_blank  = (dig3 == 4'd0);
            end
        endcase
        seg = ((BLANK_LZ != 0) && lz_blank) ? SEG_BLANK : seg_encode(sel_digit);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend       <= 14'd0;
            r_pend_full  <= 1'b0;
            r_disp       <= 14'd0;
            r_tick       <= '0;
            r_digit      <= '0;
            o_fnd_comm   <= 4'hF;
            o_fnd_font   <= 8'hFF;
            o_frame_done <= 1'b0;
        end else begin
            // Pending slot feeds the display only between frames, or at once while dark.
            if (i_clear) begin
                r_disp      <= 14'd0;
                r_pend      <= 14'd0;
                r_pend_full <= 1'b0;
            end else if (accept) begin
                r_pend      <= sat_value;
                r_pend_full <= 1'b1;
            end else if (r_pend_full && (!i_enable || frame_end)) begin
                r_disp      <= r_pend;
                r_pend_full <= 1'b0;
            end

            if (!i_enable) begin
                r_tick       <= '0;
                r_digit      <= '0;
                o_fnd_comm   <= 4'hF;
                o_fnd_font   <= 8'hFF;
                o_frame_done <= 1'b0;
            end else begin
                o_fnd_comm   <= ~(4'b0001 << r_digit);
                o_fnd_font   <= {~i_dp[r_digit], seg};
                o_frame_done <= frame_end;
                if (r_tick == TICK_LAST) begin
                    r_tick  <= '0;
                    r_digit <= r_digit + 2'd1;
                end else begin
                    r_tick <= r_tick + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb/tb_fnd_scan_controller.sv - directed self-checking bench for fnd_scan_controller
module tb_fnd_scan_controller;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [13:0] i_value;
    logic        i_valid;
    logic        o_ready;
    logic        i_clear;
    logic [3:0]  i_dp;
    logic [3:0]  o_fnd_comm;
    logic [7:0]  o_fnd_font;
    logic        o_frame_done;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] f1234 [4];
    logic [7:0] fsat  [4];

    always #5 i_clk = ~i_clk;

    fnd_scan_controller #(
        .CLK_HZ   (16),
        .SCAN_HZ  (4),
        .BLANK_LZ (1)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_value      (i_value),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_clear      (i_clear),
        .i_dp         (i_dp),
        .o_fnd_comm   (o_fnd_comm),
        .o_fnd_font   (o_fnd_font),
        .o_frame_done (o_frame_done)
    );

    task automatic step();
        @(negedge i_clk);
    endtask

    // Leaves the bench at a negedge with reset just released; the next rising edge is edge 1.
    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b1; i_enable = 1'b1; i_valid = 1'b0; i_clear = 1'b0;
        i_value = 14'd0; i_dp = 4'd0;
        step(); step();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_comm;
        logic [7:0] exp_font;
        logic       exp_fd;
        int d;
        @(negedge i_clk);
        i_reset = 1'b1; i_enable = 1'b1; i_valid = 1'b0; i_clear = 1'b0;
        i_value = 14'd0; i_dp = 4'd0;
        step();
        n_total++; if (o_fnd_comm !== 4'hF) $display("FAIL reset_comm got %h want F", o_fnd_comm); else n_pass++;
        n_total++; if (o_fnd_font !== 8'hFF) $display("FAIL reset_font got %h want FF", o_fnd_font); else n_pass++;
        n_total++; if (o_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", o_ready); else n_pass++;
        n_total++; if (o_frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", o_frame_done); else n_pass++;
        i_reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            d = ((k - 1) / 4) % 4;
            exp_comm = ~(4'b0001 << d);
            exp_font = (d == 0) ? 8'hC0 : 8'hFF;
            exp_fd   = (k == 16) || (k == 32);
            n_total++; if (o_fnd_comm !== exp_comm) $display("FAIL idle_comm k=%0d got %h want %h", k, o_fnd_comm, exp_comm); else n_pass++;
            n_total++; if (o_fnd_font !== exp_font) $display("FAIL idle_font k=%0d got %h want %h", k, o_fnd_font, exp_font); else n_pass++;
            n_total++; if (o_frame_done !== exp_fd) $display("FAIL idle_frame_done k=%0d got %b want %b", k, o_frame_done, exp_fd); else n_pass++;
        end
    endtask

    task automatic test_load_1234();
        logic [3:0] exp_comm;
        int d;
        do_reset();
        i_valid = 1'b1; i_value = 14'd1234;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 1) i_valid = 1'b0;
            d = ((k - 1) / 4) % 4;
            exp_comm = ~(4'b0001 << d);
            if (k <= 16) begin
                n_total++; if (o_ready !== (k == 16)) $display("FAIL load_ready k=%0d got %b want %b", k, o_ready, (k == 16)); else n_pass++;
            end
            if (k >= 13 && k <= 16) begin
                n_total++; if (o_fnd_font !== 8'hFF) $display("FAIL load_no_tear k=%0d got %h want FF", k, o_fnd_font); else n_pass++;
            end
            if (k >= 17) begin
                n_total++; if (o_fnd_comm !== exp_comm) $display("FAIL load_comm k=%0d got %h want %h", k, o_fnd_comm, exp_comm); else n_pass++;
                n_total++; if (o_fnd_font !== f1234[d]) $display("FAIL load_font k=%0d got %h want %h", k, o_fnd_font, f1234[d]); else n_pass++;
            end
        end
    endtask

    task automatic test_saturation_dp();
        int d;
        do_reset();
        i_valid = 1'b1; i_value = 14'd16383; i_dp = 4'b0100;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 1) i_valid = 1'b0;
            d = ((k - 1) / 4) % 4;
            if (k >= 17) begin
                n_total++; if (o_fnd_font !== fsat[d]) $display("FAIL sat_font k=%0d got %h want %h", k, o_fnd_font, fsat[d]); else n_pass++;
            end
        end
        i_dp = 4'd0;
    endtask

    task automatic test_back_pressure();
        logic found;
        do_reset();
        i_valid = 1'b1; i_value = 14'd7;
        step();
        i_value = 14'd5;
        step();
        i_valid = 1'b0;
        n_total++; if (o_ready !== 1'b0) $display("FAIL bp_ready_low got %b want 0", o_ready); else n_pass++;
        found = 1'b0;
        for (int w = 0; w < 40 && !found; w++) begin
            step();
            if (o_frame_done === 1'b1) found = 1'b1;
        end
        n_total++; if (found !== 1'b1) $display("FAIL bp_frame_done_timeout got %b want 1", found); else n_pass++;
        n_total++; if (o_ready !== 1'b1) $display("FAIL bp_ready_after_frame got %b want 1", o_ready); else n_pass++;
        i_valid = 1'b1; i_value = 14'd5;
        step();
        i_valid = 1'b0;
        n_total++; if (o_ready !== 1'b0) $display("FAIL bp_retry_accept got %b want 0", o_ready); else n_pass++;
        n_total++; if (o_fnd_font !== 8'hF8) $display("FAIL bp_first_value got %h want F8", o_fnd_font); else n_pass++;
        n_total++; if (o_fnd_comm !== 4'hE) $display("FAIL bp_first_comm got %h want E", o_fnd_comm); else n_pass++;
        found = 1'b0;
        for (int w = 0; w < 40 && !found; w++) begin
            step();
            if (o_frame_done === 1'b1) found = 1'b1;
        end
        n_total++; if (found !== 1'b1) $display("FAIL bp_frame_done2_timeout got %b want 1", found); else n_pass++;
        step();
        n_total++; if (o_fnd_font !== 8'h92) $display("FAIL bp_retry_value got %h want 92", o_fnd_font); else n_pass++;
    endtask

    task automatic test_clear_vs_accept();
        do_reset();
        i_valid = 1'b1; i_value = 14'd1234;
        step();
        i_valid = 1'b0;
        repeat (15) step();
        n_total++; if (o_ready !== 1'b1) $display("FAIL clr_pre_ready got %b want 1", o_ready); else n_pass++;
        i_clear = 1'b1; i_valid = 1'b1; i_value = 14'd42;
        step();
        i_clear = 1'b0; i_valid = 1'b0;
        n_total++; if (o_ready !== 1'b1) $display("FAIL clr_ready got %b want 1", o_ready); else n_pass++;
        n_total++; if (o_fnd_font !== 8'h99) $display("FAIL clr_prev_font got %h want 99", o_fnd_font); else n_pass++;
        step();
        n_total++; if (o_fnd_font !== 8'hC0) $display("FAIL clr_font got %h want C0", o_fnd_font); else n_pass++;
        repeat (15) step();
        n_total++; if (o_fnd_comm !== 4'hE) $display("FAIL clr_next_comm got %h want E", o_fnd_comm); else n_pass++;
        n_total++; if (o_fnd_font !== 8'hC0) $display("FAIL clr_next_font got %h want C0", o_fnd_font); else n_pass++;
    endtask

    task automatic test_mid_operation();
        do_reset();
        i_valid = 1'b1; i_value = 14'd1234;
        step();
        i_valid = 1'b0;
        repeat (25) step();
        n_total++; if (o_fnd_comm !== 4'hB) $display("FAIL mid_d2_comm got %h want B", o_fnd_comm); else n_pass++;
        n_total++; if (o_fnd_font !== 8'hA4) $display("FAIL mid_d2_font got %h want A4", o_fnd_font); else n_pass++;
        i_enable = 1'b0;
        step();
        n_total++; if (o_fnd_comm !== 4'hF) $display("FAIL dis_comm got %h want F", o_fnd_comm); else n_pass++;
        n_total++; if (o_fnd_font !== 8'hFF) $display("FAIL dis_font got %h want FF", o_fnd_font); else n_pass++;
        n_total++; if (o_frame_done !== 1'b0) $display("FAIL dis_frame_done got %b want 0", o_frame_done); else n_pass++;
        i_valid = 1'b1; i_value = 14'd9;
        step();
        i_valid = 1'b0;
        n_total++; if (o_ready !== 1'b0) $display("FAIL dis_accept got %b want 0", o_ready); else n_pass++;
        step();
        n_total++; if (o_ready !== 1'b1) $display("FAIL dis_transfer got %b want 1", o_ready); else n_pass++;
        n_total++; if (o_fnd_comm !== 4'hF) $display("FAIL dis_hold_comm got %h want F", o_fnd_comm); else n_pass++;
        step();
        i_enable = 1'b1;
        step();
        n_total++; if (o_fnd_comm !== 4'hE) $display("FAIL reen_comm got %h want E", o_fnd_comm); else n_pass++;
        n_total++; if (o_fnd_font !== 8'h90) $display("FAIL reen_font got %h want 90", o_fnd_font); else n_pass++;
        repeat (4) step();
        n_total++; if (o_fnd_comm !== 4'hD) $display("FAIL reen_d1_comm got %h want D", o_fnd_comm); else n_pass++;
        n_total++; if (o_fnd_font !== 8'hFF) $display("FAIL reen_d1_font got %h want FF", o_fnd_font); else n_pass++;
        i_valid = 1'b1; i_value = 14'd77;
        step();
        i_valid = 1'b0;
        n_total++; if (o_ready !== 1'b0) $display("FAIL mid_accept got %b want 0", o_ready); else n_pass++;
        i_reset = 1'b1;
        step();
        n_total++; if (o_fnd_comm !== 4'hF) $display("FAIL midrst_comm got %h want F", o_fnd_comm); else n_pass++;
        n_total++; if (o_fnd_font !== 8'hFF) $display("FAIL midrst_font got %h want FF", o_fnd_font); else n_pass++;
        n_total++; if (o_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", o_ready); else n_pass++;
        n_total++; if (o_frame_done !== 1'b0) $display("FAIL midrst_frame_done got %b want 0", o_frame_done); else n_pass++;
        i_reset = 1'b0;
        step();
        n_total++; if (o_fnd_comm !== 4'hE) $display("FAIL postrst_comm got %h want E", o_fnd_comm); else n_pass++;
        n_total++; if (o_fnd_font !== 8'hC0) $display("FAIL postrst_font got %h want C0", o_fnd_font); else n_pass++;
        repeat (16) step();
        n_total++; if (o_fnd_font !== 8'hC0) $display("FAIL postrst_pend_lost got %h want C0", o_fnd_font); else n_pass++;
    endtask

    initial begin
        i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_clear = 1'b0;
        i_value = 14'd0; i_dp = 4'd0;
        f1234 = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        fsat  = '{8'h90, 8'h90, 8'h10, 8'h90};
        test_reset();
        test_load_1234();
        test_saturation_dp();
        test_back_pressure();
        test_clear_vs_accept();
        test_mid_operation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Time-multiplexed 4-digit FND (7-segment) scan controller. Accepts a 14-bit binary value over a valid/ready handshake and saturates it to 9999. Splits it into decimal digits through `digitDivider` and drives one common-anode digit at a time at a fixed per-digit dwell rate. Sits between the AXI4 register file (value/enable/dp registers) and the board FND pins.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency.
- `SCAN_HZ`, 4_000, per-digit refresh rate. Dwell `DIV = CLK_HZ/SCAN_HZ` cycles, must be ≥ 2.
- `BLANK_LZ`, 1, when 1, leading zeros are blanked.

Ports. One clock; reset is synchronous and active-high.
- `i_clk`  in  1  system clock, all logic on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  scan enable; 0 turns all digits off.
- `i_value`  in  14  binary value to display.
- `i_valid`  in  1  `i_value` is offered.
- `o_ready`  out  1  pending slot empty; a value is accepted on `i_valid & o_ready`.
- `i_clear`  in  1  synchronous clear of displayed and pending value.
- `i_dp`  in  4  decimal point per digit, 1 = lit; bit n is digit n.
- `o_fnd_comm`  out  4  digit select, active-low; bit 0 is the ones digit.
- `o_fnd_font`  out  8  segments, active-low; [7] = dp, [6:0] = g..a.
- `o_frame_done`  out  1  one-cycle pulse when digit 3 dwell ends.

## Operation
- **Registers:** `r_pend` (14b) plus `r_pend_full`, `r_disp` (14b), `r_tick` (0..DIV-1), `r_digit` (2b), and registered `o_fnd_comm`/`o_fnd_font`.
- **Accept:** on `i_valid & o_ready`, `r_pend` ← min(`i_value`, 9999) and `r_pend_full` ← 1. `o_ready` = ~`r_pend_full`.
- **Frame boundary** (tick = DIV-1 and digit = 3, while enabled):
  - `r_disp` ← `r_pend` if full; `r_pend_full` ← 0.
  - Display never changes mid-frame, so there is no tearing.
- **Disabled** (`i_enable` = 0):
  - `r_tick` and `r_digit` are held at 0.
  - Outputs are forced to `comm` = 4'hF, `font` = 8'hFF.
  - `r_pend` moves to `r_disp` immediately, so values are still accepted.
- **Scan:** `r_tick` increments. At DIV-1 it wraps to 0 and `r_digit` advances 0→1→2→3→0.
- **Digit decode:**
  - `digitDivider` decodes `r_disp` combinationally; its clear input is tied to 0.
  - Selected digit d gives comm = ~(1<<d) and font = {~`i_dp`[d], SEG[digit_d]}.
- **Blanking** (`BLANK_LZ` = 1): digit d > 0 shows segments off (7'h7F) when it and all higher digits are 0. Digit 0 is never blanked. dp is unaffected by blanking.
- **Segment codes** (g..a, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F.
- **`i_clear`:** `r_disp` ← 0, `r_pend` ← 0, `r_pend_full` ← 0. Scan counters are untouched. Clear wins over a simultaneous accept (the value is dropped) and over a simultaneous frame-boundary transfer.

## Timing
- **Reset values:** `o_fnd_comm` = 4'hF, `o_fnd_font` = 8'hFF, `o_ready` = 1, `o_frame_done` = 0; `r_tick` = 0, `r_digit` = 0, `r_disp` = 0, `r_pend_full` = 0.
- **Output latency:** outputs reflect the `r_digit`/`r_disp` state of the previous cycle (1-cycle latency). A digit change appears on the pins the cycle after the tick wrap.
- **Handshake:**
  - `o_ready` deasserts the cycle after an accept.
  - It reasserts the cycle after the frame-boundary transfer or a clear.
  - `i_valid` with `o_ready` = 0 has no effect, and holding `i_valid` is not required.
- **`o_frame_done`:** registered, high for exactly the cycle after the digit-3→0 wrap.
- **Reset mid-frame:** all state returns to reset values on the next edge and the pending value is lost.
- **Enable toggling:** enable 1→0 blanks the outputs the next cycle. Enable 0→1 restarts scanning at digit 0, tick 0.

## Structure
- **Package `fnd_pkg`:** `NUM_DIGITS` = 4, `MAX_VALUE` = 9999, the `SEG_*` font constants 0–9, `SEG_BLANK`, and the digit-index typedef.
- **Sub-module:** one instance of the existing `digitDivider`. No other sub-modules; tick counter, FSM and encode stay inline.

## Test plan
All scenarios use `CLK_HZ` = 16, `SCAN_HZ` = 4 (DIV = 4), `BLANK_LZ` = 1.
- **Reset/idle:** reset, enable = 1, no value → digit 0 shows 0x40 (comm 4'hE), digits 1–3 show font 0xFF. `o_frame_done` pulses every 16 cycles.
- **Load 1234:** accept, then wait for frame boundary → comm cycles E,D,B,7, 4 cycles each, fonts 0x99, 0xB0, 0xA4, 0xF9. `o_ready` = 0 until that boundary.
- **Saturation and dp:** load 16383 with `i_dp` = 4'b0100 → every digit shows 9 (0x90), except digit 2, which shows 0x10.
- **Back-pressure:** offer 5 while pending is full → not accepted. After `o_frame_done`, `o_ready` = 1; a retry is accepted.
- **Clear vs accept:** `i_clear` and an accept of 42 in the same cycle → display 0, `o_ready` = 1 next cycle.
- **Mid-operation:** enable dropped mid-digit-2 → next cycle comm = F, font = FF. Re-enable → digit 0 first. Reset mid-frame → all reset values.
